flash_word_cache: RTL

- Read-only, direct-mapped word cache between the CPU's instruction/data read port and the SPI flash word reader.
- Serves repeated flash reads (e.g. loops executing from flash) in one cycle.
- On a miss, issues one word fetch to the flash reader, fills the line, then returns the word.
- Upstream neighbour of the flash reader: it drives that block's read strobe and word address, and consumes its data and busy outputs.

---
 rtl/flash_word_cache.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/flash_word_cache.sv
// flash_word_cache
//   Read-only, direct-mapped, one-word-per-line cache placed between the CPU
//   read port and the SPI flash word reader. Hits return data the cycle after
//   the strobe with no busy indication; misses fetch one word from the flash
//   reader, fill the line and then return the word.
//
//   Optional build macro: FLASH_CACHE_PREFETCH_EN
//     When defined, a completed miss fill is followed by a single prefetch of
//     the next word address (modulo 2^20) into its own line, unless already
//     present. A CPU strobe arriving during a prefetch is held pending.
//
//   Parameters:
//     LINES              number of one-word lines (power of two, 2..256)
//
//   Ports:
//     clk                system clock
//     resetn             asynchronous active-low reset
//     mem_rstrb          one-cycle CPU read strobe
//     mem_word_address   CPU word address (20 bits)
//     mem_rdata          read data returned to the CPU (held between reads)
//     mem_rbusy          high while a CPU read is outstanding
//     flush              one-cycle pulse invalidating every line
//     flash_rstrb        one-cycle read strobe to the flash reader
//     flash_word_address word address presented to the flash reader
//     flash_rdata        word from the flash reader
//     flash_rbusy        flash reader busy (registered inside the reader)
module flash_word_cache #(
    parameter int unsigned LINES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_rstrb,
    input  logic [19:0] mem_word_address,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    input  logic        flush,
    output logic        flash_rstrb,
    output logic [19:0] flash_word_address,
    input  logic [31:0] flash_rdata,
    input  logic        flash_rbusy
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 20 - IDX_W;

`ifdef FLASH_CACHE_PREFETCH_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PF_ISSUE, PF_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic             first_wait;   // first WAIT cycle: reader busy not yet visible
    logic             kill;         // flush seen during this fetch: do not validate

    logic             lk_req;
    logic [19:0]      lk_addr;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             in_wait;
    logic             fill_done;
    logic [IDX_W-1:0] fill_idx;

`ifdef FLASH_CACHE_PREFETCH_EN
    logic             pend;
    logic [19:0]      pend_addr;
    logic [19:0]      next_addr;
    logic [IDX_W-1:0] next_idx;
    logic             next_present;
`endif

    always_comb begin
`ifdef FLASH_CACHE_PREFETCH_EN
        // A pending request holds mem_rbusy high, so new CPU strobes are ignored.
        lk_req  = pend | mem_rstrb;
        lk_addr = pend ? pend_addr : mem_word_address;
        in_wait = (state == WAIT) || (state == PF_WAIT);
`else
        lk_req  = mem_rstrb;
        lk_addr = mem_word_address;
        in_wait = (state == WAIT);
`endif
        lk_idx    = lk_addr[IDX_W-1:0];
        lk_tag    = lk_addr[19:IDX_W];
        // A flush coinciding with the strobe forces a miss.
        lk_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag) && !flush;
        fill_idx  = flash_word_address[IDX_W-1:0];
        fill_done = in_wait && !first_wait && !flash_rbusy;
    end

`ifdef FLASH_CACHE_PREFETCH_EN
    always_comb begin
        next_addr    = flash_word_address + 20'd1;
        next_idx     = next_addr[IDX_W-1:0];
        next_present = valid[next_idx] && (tag_mem[next_idx] == next_addr[19:IDX_W]) && !flush;
    end
`endif

    // Tag/data storage carries no reset; only the valid bits do.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_mem[fill_idx] <= flash_rdata;
            tag_mem[fill_idx]  <= flash_word_address[19:IDX_W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state              <= IDLE;
            valid              <= '0;
            mem_rdata          <= '0;
            mem_rbusy          <= 1'b0;
            flash_rstrb        <= 1'b0;
            flash_word_address <= '0;
            first_wait         <= 1'b0;
            kill               <= 1'b0;
`ifdef FLASH_CACHE_PREFETCH_EN
            pend               <= 1'b0;
            pend_addr          <= '0;
`endif
        end else begin
            flash_rstrb <= 1'b0;

            // Flush clears first; a fill in the same cycle must not re-validate.
            if (flush)
                valid <= '0;
            if (fill_done && !kill && !flush)
                valid[fill_idx] <= 1'b1;

            case (state)
                IDLE: begin
                    if (lk_req) begin
                        if (lk_hit) begin
                            mem_rdata <= data_mem[lk_idx];
                            mem_rbusy <= 1'b0;
                        end else begin
                            flash_word_address <= lk_addr;
                            mem_rbusy          <= 1'b1;
                            kill               <= 1'b0;
                            state              <= ISSUE;
                        end
`ifdef FLASH_CACHE_PREFETCH_EN
                        pend <= 1'b0;
`endif
                    end
                end

                ISSUE: begin
                    if (flush)
                        kill <= 1'b1;
                    if (!flash_rbusy) begin
                        flash_rstrb <= 1'b1;
                        first_wait  <= 1'b1;
                        state       <= WAIT;
                    end
                end

                WAIT: begin
                    first_wait <= 1'b0;
                    if (flush)
                        kill <= 1'b1;
                    if (fill_done) begin
                        mem_rdata <= flash_rdata;
                        mem_rbusy <= 1'b0;
                        state     <= IDLE;
`ifdef FLASH_CACHE_PREFETCH_EN
                        if (!next_present) begin
                            flash_word_address <= next_addr;
                            kill               <= 1'b0;
                            state              <= PF_ISSUE;
                        end
`endif
                    end
                end

`ifdef FLASH_CACHE_PREFETCH_EN
                PF_ISSUE: begin
                    if (flush)
                        kill <= 1'b1;
                    if (mem_rstrb && !pend) begin
                        pend      <= 1'b1;
                        pend_addr <= mem_word_address;
                        mem_rbusy <= 1'b1;
                    end
                    if (!flash_rbusy) begin
                        flash_rstrb <= 1'b1;
                        first_wait  <= 1'b1;
                        state       <= PF_WAIT;
                    end
                end

                PF_WAIT: begin
                    first_wait <= 1'b0;
                    if (flush)
                        kill <= 1'b1;
                    if (mem_rstrb && !pend) begin
                        pend      <= 1'b1;
                        pend_addr <= mem_word_address;
                        mem_rbusy <= 1'b1;
                    end
                    // Pending request (if any) is looked up from IDLE next cycle.
                    if (fill_done)
                        state <= IDLE;
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule
